// File: rtl/sys_defs.sv
// Shared decode types, opcodes and default sizing for the issue-stage dispatch queue.
`default_nettype none

package sys_defs;

  localparam int IS_W     = 2;
  localparam int IS_DEPTH = 8;

  localparam logic [31:0] WFI_INST = 32'h1050_0073;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    OPA_IS_RS1,
    OPA_IS_NPC,
    OPA_IS_PC,
    OPA_IS_ZERO
  } ALU_OPA_SELECT;

  typedef enum logic [2:0] {
    OPB_IS_RS2,
    OPB_IS_I_IMM,
    OPB_IS_S_IMM,
    OPB_IS_B_IMM,
    OPB_IS_U_IMM,
    OPB_IS_J_IMM
  } ALU_OPB_SELECT;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLT,
    ALU_SLTU,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA
  } ALU_FUNC;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        valid;
  } IF_ID_PACKET;

  typedef struct packed {
    logic [31:0]   inst;
    logic [31:0]   pc;
    logic [31:0]   npc;
    ALU_OPA_SELECT opa_select;
    ALU_OPB_SELECT opb_select;
    logic [4:0]    dest_reg_idx;
    ALU_FUNC       alu_func;
    logic          rd_mem;
    logic          wr_mem;
    logic          cond_branch;
    logic          uncond_branch;
    logic          halt;
    logic          illegal;
    logic          csr_op;
    logic          valid;
    logic [4:0]    rs1_idx;
    logic [4:0]    rs2_idx;
  } DISP_PACKET;

  // Only the fields the dispatch selector needs to judge hazards.
  typedef struct packed {
    logic [4:0] rs1_idx;
    logic [4:0] rs2_idx;
    logic [4:0] dest_reg_idx;
    logic       is_mem;
    logic       halt;
  } SEL_INFO;

  function automatic ALU_FUNC alu_from_funct3(input logic [2:0] funct3, input logic alt);
    ALU_FUNC f;
    case (funct3)
      3'b000:  f = alt ? ALU_SUB : ALU_ADD;
      3'b001:  f = ALU_SLL;
      3'b010:  f = ALU_SLT;
      3'b011:  f = ALU_SLTU;
      3'b100:  f = ALU_XOR;
      3'b101:  f = alt ? ALU_SRA : ALU_SRL;
      3'b110:  f = ALU_OR;
      default: f = ALU_AND;
    endcase
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/decoder.sv
// RV32I decoder: turns one fetched instruction into a dispatch packet.
`default_nettype none

module decoder
  import sys_defs::*;
(
  input  IF_ID_PACKET if_packet_i,
  output DISP_PACKET  disp_packet_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;

  assign opcode = if_packet_i.inst[6:0];
  assign rd     = if_packet_i.inst[11:7];
  assign funct3 = if_packet_i.inst[14:12];
  assign rs1    = if_packet_i.inst[19:15];
  assign rs2    = if_packet_i.inst[24:20];
  assign funct7 = if_packet_i.inst[31:25];

  // Unused source fields are forced to x0 so immediates never look like dependences.
  always_comb begin
    disp_packet_o            = '0;
    disp_packet_o.inst       = if_packet_i.inst;
    disp_packet_o.pc         = if_packet_i.pc;
    disp_packet_o.npc        = if_packet_i.npc;
    disp_packet_o.valid      = if_packet_i.valid;
    disp_packet_o.opa_select = OPA_IS_RS1;
    disp_packet_o.opb_select = OPB_IS_RS2;
    disp_packet_o.alu_func   = ALU_ADD;
    case (opcode)
      OP_LUI: begin
        disp_packet_o.dest_reg_idx = rd;
        disp_packet_o.opa_select   = OPA_IS_ZERO;
        disp_packet_o.opb_select   = OPB_IS_U_IMM;
      end
      OP_AUIPC: begin
        disp_packet_o.dest_reg_idx = rd;
        disp_packet_o.opa_select   = OPA_IS_PC;
        disp_packet_o.opb_select   = OPB_IS_U_IMM;
      end
      OP_JAL: begin
        disp_packet_o.dest_reg_idx  = rd;
        disp_packet_o.opa_select    = OPA_IS_PC;
        disp_packet_o.opb_select    = OPB_IS_J_IMM;
        disp_packet_o.uncond_branch = 1'b1;
      end
      OP_JALR: begin
        disp_packet_o.dest_reg_idx  = rd;
        disp_packet_o.rs1_idx       = rs1;
        disp_packet_o.opb_select    = OPB_IS_I_IMM;
        disp_packet_o.uncond_branch = 1'b1;
        disp_packet_o.illegal       = (funct3 != 3'b000);
      end
      OP_BRANCH: begin
        disp_packet_o.rs1_idx     = rs1;
        disp_packet_o.rs2_idx     = rs2;
        disp_packet_o.opa_select  = OPA_IS_PC;
        disp_packet_o.opb_select  = OPB_IS_B_IMM;
        disp_packet_o.cond_branch = 1'b1;
        disp_packet_o.illegal     = (funct3[2:1] == 2'b01);
      end
      OP_LOAD: begin
        disp_packet_o.dest_reg_idx = rd;
        disp_packet_o.rs1_idx      = rs1;
        disp_packet_o.opb_select   = OPB_IS_I_IMM;
        disp_packet_o.rd_mem       = 1'b1;
        disp_packet_o.illegal      = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      end
      OP_STORE: begin
        disp_packet_o.rs1_idx    = rs1;
        disp_packet_o.rs2_idx    = rs2;
        disp_packet_o.opb_select = OPB_IS_S_IMM;
        disp_packet_o.wr_mem     = 1'b1;
        disp_packet_o.illegal    = funct3[2] || (funct3[1:0] == 2'b11);
      end
      OP_IMM: begin
        disp_packet_o.dest_reg_idx = rd;
        disp_packet_o.rs1_idx      = rs1;
        disp_packet_o.opb_select   = OPB_IS_I_IMM;
        disp_packet_o.alu_func     = alu_from_funct3(funct3, (funct3 == 3'b101) && funct7[5]);
        disp_packet_o.illegal      = ((funct3 == 3'b001) && (funct7 != 7'h00)) ||
                                     ((funct3 == 3'b101) && (funct7 != 7'h00) && (funct7 != 7'h20));
      end
      OP_REG: begin
        disp_packet_o.dest_reg_idx = rd;
        disp_packet_o.rs1_idx      = rs1;
        disp_packet_o.rs2_idx      = rs2;
        disp_packet_o.alu_func     = alu_from_funct3(funct3, funct7[5]);
        disp_packet_o.illegal      = !((funct7 == 7'h00) ||
                                       ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OP_SYSTEM: begin
        if (if_packet_i.inst == WFI_INST) begin
          disp_packet_o.halt = 1'b1;
        end else if (funct3 != 3'b000) begin
          disp_packet_o.csr_op       = 1'b1;
          disp_packet_o.dest_reg_idx = rd;
          disp_packet_o.rs1_idx      = funct3[2] ? 5'd0 : rs1;
          disp_packet_o.illegal      = (funct3 == 3'b100);
        end else begin
          disp_packet_o.illegal = 1'b1;
        end
      end
      default: disp_packet_o.illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/is_dispatch_select.sv
// Chooses how many head lanes may dispatch this cycle given resources and hazards.
`default_nettype none

module is_dispatch_select
  import sys_defs::*;
#(
  parameter  int W     = IS_W,
  parameter  int DEPTH = IS_DEPTH,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int DC_W  = $clog2(W) + 1
) (
  input  SEL_INFO [W-1:0]   head_info_i,
  input  logic [CNT_W-1:0]  occupancy_i,
  input  logic [CNT_W-1:0]  rob_free_i,
  input  logic [CNT_W-1:0]  rs_free_i,
  input  logic              lsq_free_i,
  input  logic              halted_i,
  input  logic              squash_i,
  output logic [DC_W-1:0]   disp_count_o
);

  logic            stop;
  logic            blk;
  logic            mem_used;
  logic            halt_seen;
  logic [DC_W-1:0] count;

  // Walk lanes in order; the first blocked lane stops everything behind it.
  always_comb begin
    stop      = squash_i || halted_i;
    blk       = 1'b0;
    mem_used  = 1'b0;
    halt_seen = 1'b0;
    count     = '0;
    for (int i = 0; i < W; i++) begin
      blk = stop || halt_seen ||
            (i >= int'(occupancy_i)) ||
            (i >= int'(rob_free_i)) ||
            (i >= int'(rs_free_i));
      for (int j = 0; j < i; j++) begin
        if ((head_info_i[j].dest_reg_idx != 5'd0) &&
            ((head_info_i[i].rs1_idx == head_info_i[j].dest_reg_idx) ||
             (head_info_i[i].rs2_idx == head_info_i[j].dest_reg_idx))) begin
          blk = 1'b1;
        end
      end
      if (head_info_i[i].is_mem && (mem_used || !lsq_free_i)) begin
        blk = 1'b1;
      end
      if (!blk) begin
        count     = count + 1'b1;
        mem_used  = mem_used || head_info_i[i].is_mem;
        halt_seen = halt_seen || head_info_i[i].halt;
      end
      stop = blk;
    end
  end

  assign disp_count_o = count;

endmodule

`default_nettype wire

// File: rtl/is_dispatch_queue.sv
// Circular dispatch queue: decodes up to W fetched instructions per cycle and dispatches up to W in order.
`default_nettype none

module is_dispatch_queue
  import sys_defs::*;
#(
  parameter  int W     = IS_W,
  parameter  int DEPTH = IS_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1,
  localparam int DC_W  = $clog2(W) + 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [W-1:0]        if_valid,
  input  IF_ID_PACKET [W-1:0] if_packet,
  output logic                in_ready,
  input  logic [CNT_W-1:0]    rob_free,
  input  logic [CNT_W-1:0]    rs_free,
  input  logic                lsq_free,
  input  logic                squash,
  output logic [W-1:0]        disp_valid,
  output DISP_PACKET [W-1:0]  disp_packet,
  output logic [DC_W-1:0]     disp_count,
  output logic [CNT_W-1:0]    occupancy,
  output logic                halted
);

  DISP_PACKET         mem_q [DEPTH];
  DISP_PACKET [W-1:0] dec_pkt;
  SEL_INFO    [W-1:0] sel_info;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] enq_cnt;
  logic             disp_halt;

  for (genvar g = 0; g < W; g++) begin : g_dec
    decoder u_dec (
      .if_packet_i   (if_packet[g]),
      .disp_packet_o (dec_pkt[g])
    );
  end

  assign in_ready  = (occ_q <= CNT_W'(DEPTH - W)) && !halted_q && !squash;
  assign occupancy = occ_q;
  assign halted    = halted_q;

  // Valid lanes are contiguous from lane 0, so the popcount is also the tail advance.
  always_comb begin
    enq_cnt = '0;
    if (in_ready) begin
      for (int i = 0; i < W; i++) begin
        enq_cnt = enq_cnt + CNT_W'(if_valid[i]);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < W; i++) begin
      disp_packet[i]           = mem_q[head_q + PTR_W'(i)];
      sel_info[i].rs1_idx      = disp_packet[i].rs1_idx;
      sel_info[i].rs2_idx      = disp_packet[i].rs2_idx;
      sel_info[i].dest_reg_idx = disp_packet[i].dest_reg_idx;
      sel_info[i].is_mem       = disp_packet[i].rd_mem || disp_packet[i].wr_mem;
      sel_info[i].halt         = disp_packet[i].halt;
    end
  end

  is_dispatch_select #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_select (
    .head_info_i  (sel_info),
    .occupancy_i  (occ_q),
    .rob_free_i   (rob_free),
    .rs_free_i    (rs_free),
    .lsq_free_i   (lsq_free),
    .halted_i     (halted_q),
    .squash_i     (squash),
    .disp_count_o (disp_count)
  );

  always_comb begin
    disp_halt = 1'b0;
    for (int i = 0; i < W; i++) begin
      disp_valid[i] = (i < int'(disp_count));
      disp_halt     = disp_halt || (disp_valid[i] && disp_packet[i].halt);
    end
  end

  always_comb begin
    head_d   = head_q + PTR_W'(disp_count);
    tail_d   = tail_q + PTR_W'(enq_cnt);
    occ_d    = occ_q + enq_cnt - CNT_W'(disp_count);
    halted_d = halted_q || disp_halt;
    if (squash) begin
      head_d   = '0;
      tail_d   = '0;
      occ_d    = '0;
      halted_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      occ_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      occ_q    <= occ_d;
      halted_q <= halted_d;
    end
  end

  // Payload is qualified by occupancy, so it carries no reset.
  always_ff @(posedge clock) begin
    for (int i = 0; i < W; i++) begin
      if (in_ready && if_valid[i]) begin
        mem_q[tail_q + PTR_W'(i)] <= dec_pkt[i];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_is_dispatch_queue.sv
// Directed bench for is_dispatch_queue at W=2, DEPTH=8.
`default_nettype none

module tb_is_dispatch_queue;
  import sys_defs::*;

  logic              clock = 1'b0;
  logic              reset;
  logic [1:0]        if_valid;
  IF_ID_PACKET [1:0] if_packet;
  logic              in_ready;
  logic [3:0]        rob_free;
  logic [3:0]        rs_free;
  logic              lsq_free;
  logic              squash;
  logic [1:0]        disp_valid;
  DISP_PACKET [1:0]  disp_packet;
  logic [1:0]        disp_count;
  logic [3:0]        occupancy;
  logic              halted;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  is_dispatch_queue #(.W(2), .DEPTH(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .if_valid    (if_valid),
    .if_packet   (if_packet),
    .in_ready    (in_ready),
    .rob_free    (rob_free),
    .rs_free     (rs_free),
    .lsq_free    (lsq_free),
    .squash      (squash),
    .disp_valid  (disp_valid),
    .disp_packet (disp_packet),
    .disp_count  (disp_count),
    .occupancy   (occupancy),
    .halted      (halted)
  );

  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
  endfunction

  function automatic logic [31:0] add(input int rd, input int rs1, input int rs2);
    return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] lw(input int rd, input int rs1, input int imm);
    return {12'(imm), 5'(rs1), 3'b010, 5'(rd), 7'b0000011};
  endfunction

  function automatic logic [31:0] sw(input int rs2, input int rs1, input int imm);
    logic [11:0] im;
    im = 12'(imm);
    return {im[11:5], 5'(rs2), 5'(rs1), 3'b010, im[4:0], 7'b0100011};
  endfunction

  task automatic put(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                     input logic [31:0] pc);
    if_valid           = v;
    if_packet[0].inst  = i0;
    if_packet[0].pc    = pc;
    if_packet[0].npc   = pc + 32'd4;
    if_packet[0].valid = v[0];
    if_packet[1].inst  = i1;
    if_packet[1].pc    = pc + 32'd4;
    if_packet[1].npc   = pc + 32'd8;
    if_packet[1].valid = v[1];
  endtask

  task automatic idle();
    put(2'b00, 32'h0, 32'h0, 32'h0);
    rob_free = 4'd4;
    rs_free  = 4'd4;
    lsq_free = 1'b1;
    squash   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    @(negedge clock); #1;
    vectors++; if (occupancy !== 4'd0) begin miscompares++; $display("FAIL rst_occ got=%0d exp=0", occupancy); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready got=%b exp=1", in_ready); end
    vectors++; if (disp_valid !== 2'b00) begin miscompares++; $display("FAIL rst_dvalid got=%b exp=00", disp_valid); end
    vectors++; if (disp_count !== 2'd0) begin miscompares++; $display("FAIL rst_dcount got=%0d exp=0", disp_count); end
    vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL rst_halted got=%b exp=0", halted); end
    reset = 1'b1;
    @(negedge clock); #1;
    vectors++; if (occupancy !== 4'd0) begin miscompares++; $display("FAIL idle_occ got=%0d exp=0", occupancy); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL idle_ready got=%b exp=1", in_ready); end
    vectors++; if (disp_valid !== 2'b00) begin miscompares++; $display("FAIL idle_dvalid got=%b exp=00", disp_valid); end
  endtask

  task automatic test_basic();
    @(negedge clock);
    put(2'b11, addi(1, 0, 1), addi(2, 0, 2), 32'h100);
    #1;
    vectors++; if (disp_valid !== 2'b00) begin miscompares++; $display("FAIL basic_nobypass got=%b exp=00", disp_valid); end
    @(negedge clock);
    put(2'b00, 32'h0, 32'h0, 32'h0);
    #1;
    vectors++; if (disp_valid !== 2'b11) begin miscompares++; $display("FAIL basic_dvalid got=%b exp=11", disp_valid); end
    vectors++; if (disp_count !== 2'd2) begin miscompares++; $display("FAIL basic_dcount got=%0d exp=2", disp_count); end
    vectors++; if (occupancy !== 4'd2) begin miscompares++; $display("FAIL basic_occ got=%0d exp=2", occupancy); end
    vectors++; if (disp_packet[0].inst !== addi(1, 0, 1)) begin miscompares++; $display("FAIL basic_pkt0 got=%h exp=%h", disp_packet[0].inst, addi(1, 0, 1)); end
    vectors++; if (disp_packet[1].inst !== addi(2, 0, 2)) begin miscompares++; $display("FAIL basic_pkt1 got=%h exp=%h", disp_packet[1].inst, addi(2, 0, 2)); end
    vectors++; if (disp_packet[1].pc !== 32'h104) begin miscompares++; $display("FAIL basic_pc1 got=%h exp=104", disp_packet[1].pc); end
    vectors++; if (disp_packet[0].dest_reg_idx !== 5'd1) begin miscompares++; $display("FAIL basic_dest0 got=%0d exp=1", disp_packet[0].dest_reg_idx); end
    @(negedge clock); #1;
    vectors++; if (occupancy !== 4'd0) begin miscompares++; $display("FAIL basic_drain got=%0d exp=0", occupancy); end
  endtask

  task automatic test_rob_wrap();
    rob_free = 4'd1;
    @(negedge clock);
    put(2'b11, addi(3, 0, 0), addi(3, 0, 1), 32'h200);
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      put(2'b01, addi(3, 0, k + 2), 32'h0, 32'h200 + 32'(4 * (k + 2)));
      #1;
      vectors++; if (occupancy !== 4'd2) begin miscompares++; $display("FAIL wrap_occ k=%0d got=%0d exp=2", k, occupancy); end
      vectors++; if (disp_count !== 2'd1) begin miscompares++; $display("FAIL wrap_dcount k=%0d got=%0d exp=1", k, disp_count); end
      vectors++; if (disp_packet[0].inst !== addi(3, 0, k)) begin miscompares++; $display("FAIL wrap_pkt0 k=%0d got=%h exp=%h", k, disp_packet[0].inst, addi(3, 0, k)); end
      vectors++; if (disp_packet[1].inst !== addi(3, 0, k + 1)) begin miscompares++; $display("FAIL wrap_pkt1 k=%0d got=%h exp=%h", k, disp_packet[1].inst, addi(3, 0, k + 1)); end
    end
    @(negedge clock);
    put(2'b00, 32'h0, 32'h0, 32'h0);
    rob_free = 4'd4;
    #1;
    vectors++; if (disp_count !== 2'd2) begin miscompares++; $display("FAIL wrap_tail_dcount got=%0d exp=2", disp_count); end
    vectors++; if (disp_packet[0].inst !== addi(3, 0, 20)) begin miscompares++; $display("FAIL wrap_tail_pkt0 got=%h exp=%h", disp_packet[0].inst, addi(3, 0, 20)); end
    vectors++; if (disp_packet[1].inst !== addi(3, 0, 21)) begin miscompares++; $display("FAIL wrap_tail_pkt1 got=%h exp=%h", disp_packet[1].inst, addi(3, 0, 21)); end
    @(negedge clock); #1;
    vectors++; if (occupancy !== 4'd0) begin miscompares++; $display("FAIL wrap_drain got=%0d exp=0", occupancy); end
  endtask

  task automatic test_dependence();
    @(negedge clock);
    put(2'b11, addi(5, 0, 5), add(6, 5, 1), 32'h300);
    @(negedge clock);
    put(2'b00, 32'h0, 32'h0, 32'h0);
    #1;
    vectors++; if (disp_valid !== 2'b01) begin miscompares++; $display("FAIL dep_dvalid got=%b exp=01", disp_valid); end
    @(negedge clock); #1;
    vectors++; if (occupancy !== 4'd1) begin miscompares++; $display("FAIL dep_occ got=%0d exp=1", occupancy); end
    vectors++; if (disp_packet[0].inst !== add(6, 5, 1)) begin miscompares++; $display("FAIL dep_pkt0 got=%h exp=%h", disp_packet[0].inst, add(6, 5, 1)); end
    vectors++; if (disp_valid !== 2'b01) begin miscompares++; $display("FAIL dep_second got=%b exp=01", disp_valid); end
    @(negedge clock);
    put(2'b11, addi(5, 0, 5), add(7, 1, 2), 32'h320);
    @(negedge clock);
    put(2'b00, 32'h0, 32'h0, 32'h0);
    #1;
    vectors++; if (disp_valid !== 2'b11) begin miscompares++; $display("FAIL nodep_dvalid got=%b exp=11", disp_valid); end
    @(negedge clock); #1;
  endtask

  task automatic test_memory();
    @(negedge clock);
    put(2'b11, lw(7, 1, 0), sw(8, 2, 4), 32'h400);
    @(negedge clock);
    put(2'b00, 32'h0, 32'h0, 32'h0);
    #1;
    vectors++; if (disp_valid !== 2'b01) begin miscompares++; $display("FAIL mem_one got=%b exp=01", disp_valid); end
    @(negedge clock);
    lsq_free = 1'b0;
    #1;
    vectors++; if (occupancy !== 4'd1) begin miscompares++; $display("FAIL mem_occ got=%0d exp=1", occupancy); end
    vectors++; if (disp_count !== 2'd0) begin miscompares++; $display("FAIL mem_nolsq got=%0d exp=0", disp_count); end
    vectors++; if (disp_packet[0].inst !== sw(8, 2, 4)) begin miscompares++; $display("FAIL mem_pkt0 got=%h exp=%h", disp_packet[0].inst, sw(8, 2, 4)); end
    @(negedge clock);
    lsq_free = 1'b1;
    #1;
    vectors++; if (disp_count !== 2'd1) begin miscompares++; $display("FAIL mem_lsq got=%0d exp=1", disp_count); end
    @(negedge clock); #1;
    vectors++; if (occupancy !== 4'd0) begin miscompares++; $display("FAIL mem_drain got=%0d exp=0", occupancy); end
  endtask

  task automatic test_fill_squash();
    rob_free = 4'd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      put(2'b11, addi(3, 0, 2 * k), addi(3, 0, 2 * k + 1), 32'h500);
      #1;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL fill_ready k=%0d got=%b exp=1", k, in_ready); end
    end
    @(negedge clock);
    put(2'b01, addi(3, 0, 6), 32'h0, 32'h500);
    #1;
    vectors++; if (occupancy !== 4'd6) begin miscompares++; $display("FAIL fill_occ6 got=%0d exp=6", occupancy); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL fill_ready6 got=%b exp=1", in_ready); end
    @(negedge clock);
    put(2'b11, addi(3, 0, 7), addi(3, 0, 8), 32'h500);
    #1;
    vectors++; if (occupancy !== 4'd7) begin miscompares++; $display("FAIL fill_occ7 got=%0d exp=7", occupancy); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL fill_ready7 got=%b exp=0", in_ready); end
    @(negedge clock);
    squash   = 1'b1;
    rob_free = 4'd4;
    #1;
    vectors++; if (occupancy !== 4'd7) begin miscompares++; $display("FAIL fill_dropped got=%0d exp=7", occupancy); end
    vectors++; if (disp_valid !== 2'b00) begin miscompares++; $display("FAIL squash_dvalid got=%b exp=00", disp_valid); end
    @(negedge clock);
    squash = 1'b0;
    put(2'b00, 32'h0, 32'h0, 32'h0);
    #1;
    vectors++; if (occupancy !== 4'd0) begin miscompares++; $display("FAIL squash_occ got=%0d exp=0", occupancy); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL squash_ready got=%b exp=1", in_ready); end
    vectors++; if (disp_valid !== 2'b00) begin miscompares++; $display("FAIL squash_after got=%b exp=00", disp_valid); end
  endtask

  task automatic test_halt();
    @(negedge clock);
    put(2'b11, 32'h1050_0073, addi(4, 0, 4), 32'h600);
    @(negedge clock);
    put(2'b00, 32'h0, 32'h0, 32'h0);
    #1;
    vectors++; if (disp_valid !== 2'b01) begin miscompares++; $display("FAIL halt_dvalid got=%b exp=01", disp_valid); end
    vectors++; if (disp_packet[0].halt !== 1'b1) begin miscompares++; $display("FAIL halt_flag got=%b exp=1", disp_packet[0].halt); end
    vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL halt_early got=%b exp=0", halted); end
    @(negedge clock); #1;
    vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL halt_set got=%b exp=1", halted); end
    vectors++; if (disp_count !== 2'd0) begin miscompares++; $display("FAIL halt_dcount got=%0d exp=0", disp_count); end
    vectors++; if (occupancy !== 4'd1) begin miscompares++; $display("FAIL halt_occ got=%0d exp=1", occupancy); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL halt_ready got=%b exp=0", in_ready); end
    @(negedge clock); #1;
    vectors++; if (disp_valid !== 2'b00) begin miscompares++; $display("FAIL halt_stay got=%b exp=00", disp_valid); end
    @(negedge clock);
    squash = 1'b1;
    @(negedge clock);
    squash = 1'b0;
    #1;
    vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL halt_clear got=%b exp=0", halted); end
    vectors++; if (occupancy !== 4'd0) begin miscompares++; $display("FAIL halt_sq_occ got=%0d exp=0", occupancy); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL halt_sq_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_reset_midop();
    rob_free = 4'd0;
    @(negedge clock);
    put(2'b11, addi(9, 0, 1), addi(10, 0, 2), 32'h700);
    @(negedge clock);
    put(2'b00, 32'h0, 32'h0, 32'h0);
    rob_free = 4'd4;
    #1;
    vectors++; if (disp_count !== 2'd2) begin miscompares++; $display("FAIL mid_pre got=%0d exp=2", disp_count); end
    reset = 1'b0;
    #1;
    vectors++; if (occupancy !== 4'd0) begin miscompares++; $display("FAIL mid_occ got=%0d exp=0", occupancy); end
    vectors++; if (disp_valid !== 2'b00) begin miscompares++; $display("FAIL mid_dvalid got=%b exp=00", disp_valid); end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock); #1;
    vectors++; if (occupancy !== 4'd0) begin miscompares++; $display("FAIL mid_after got=%0d exp=0", occupancy); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_ready got=%b exp=1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rob_wrap();
    test_dependence();
    test_memory();
    test_fill_squash();
    test_halt();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/is_dispatch_queue.md
IS_DISPATCH_QUEUE -- requirements
Module: is_dispatch_queue

Interface
REQ-001 Parameter W, default 2: lanes per cycle, for both enqueue and dispatch.
REQ-002 Parameter DEPTH, default 8: queue entries; must be a power of 2 and >= 2*W.
REQ-003 Ports, in order:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-low.
- if_valid  in  W  lane valid; valid lanes contiguous from lane 0.
- if_packet  in  W x IF_ID_PACKET  fetched instructions.
- in_ready  out  1  queue can accept a full group.
- rob_free  in  $clog2(DEPTH)+1  free ROB slots this cycle.
- rs_free  in  $clog2(DEPTH)+1  free RS slots this cycle.
- lsq_free  in  1  load/store slot available.
- squash  in  1  flush on mispredict or exception.
- disp_valid  out  W  lane dispatched this cycle.
- disp_packet  out  W x DISP_PACKET  decoded head entries.
- disp_count  out  $clog2(W)+1  lanes dispatched.
- occupancy  out  $clog2(DEPTH)+1  valid entries.
- halted  out  1  WFI dispatched.

Function
REQ-004 Enqueue: when in_ready=1, the contiguous valid lanes are decoded by W decoder instances and written at tail in lane order. The tail advances by popcount(if_valid).
REQ-005 in_ready = (DEPTH - occupancy >= W) && !halted && !squash.
- Enqueue with in_ready=0 is dropped.
- Non-contiguous if_valid is a protocol violation.
REQ-006 An entry written at edge N is visible at the head from cycle N+1 (1-cycle latency). There is no bypass from input to output.
REQ-007 disp_packet[i] is the entry at head+i (mod DEPTH) and is combinational from queue state.
REQ-008 disp_count = the largest k <= min(occupancy, W, rob_free, rs_free) such that none of lanes 0..k-1 violates REQ-009 to REQ-011. disp_valid is the thermometer code of disp_count.
REQ-009 Intra-group dependence: lane i (i>0) is blocked when its rs1 or rs2 equals a non-zero dest_reg_idx of any lane j<i in the group. The blocked lane and all later lanes wait.
REQ-010 Memory: at most one rd_mem/wr_mem entry is dispatched per cycle, and only when lsq_free=1.
REQ-011 Halt: a halt entry may dispatch only as the last lane of its group. Once it dispatches, halted sets on the next edge, and then disp_count=0 and in_ready=0.
REQ-012 Illegal-decoded entries dispatch normally with illegal=1; the commit stage handles them.
REQ-013 Head advances by disp_count at each edge. Pointers wrap modulo DEPTH.
REQ-014 Occupancy update: occupancy_next = occupancy + enq - disp_count. Simultaneous enqueue and dispatch are both honoured, including when the queue is full or empty.
REQ-015 Squash has priority over everything else:
- In the squash cycle, disp_valid=0 and enqueue is dropped.
- Next cycle: head=tail=0, occupancy=0, halted=0.

Reset
REQ-016 While reset=0 (asynchronous), and for the first cycle after release:
- head=tail=0, occupancy=0, halted=0.
- disp_valid=0, disp_count=0, in_ready=1.
REQ-017 Queue payload storage is not reset. Its contents are don't-care while the entry is invalid.
REQ-018 Reset asserted mid-operation discards all entries immediately, with no partial dispatch.

Structure
REQ-019 The shared sys_defs package holds:
- DISP_PACKET: the ID_EX_PACKET decode fields plus rs1_idx and rs2_idx.
- Default constants IS_W and IS_DEPTH.
REQ-020 Storage is a circular buffer with head and tail pointers. W instances of the existing decoder are placed on the enqueue path.
REQ-021 One sub-module is permitted: is_dispatch_select, the combinational disp_count logic implementing REQ-008 to REQ-011.

Verification (W=2, DEPTH=8)
REQ-022 Reset, then idle -> occupancy=0, in_ready=1, disp_valid=2'b00.
REQ-023 Cycle 0: enqueue ADDI x1 and ADDI x2, with rob_free=4 and rs_free=4 -> cycle 1: disp_valid=2'b11, disp_count=2; cycle 2: occupancy=0.
REQ-024 Resource-limited dispatch and wrap:
- Two entries queued, rob_free=1 -> disp_count=1; the former lane 1 appears in lane 0 next cycle.
- Repeating this for 20 cycles wraps the pointers with no loss or reordering.
REQ-025 Dependence and memory limits:
- ADDI x5 followed by ADD x6,x5,x1 -> disp_valid=2'b01.
- LW followed by SW with lsq_free=1 -> disp_valid=2'b01.
- Any memory entry at the head with lsq_free=0 -> disp_count=0.
REQ-026 Fill, then squash:
- Fill to occupancy 7 -> in_ready=0.
- Assert squash together with an if_valid=2'b11 enqueue -> next cycle occupancy=0 and in_ready=1.
REQ-027 Halt ordering: WFI in lane 0 with ADDI in lane 1 -> disp_valid=2'b01; halted=1 next cycle; no further dispatch until squash.
